// File: rtl/vga_sync_decoder_if.sv
// Bundle between a VGA sync/colour source and the sync decoder.
// The pixel stream is valid-only: oPix_Valid marks a one-cycle beat that the
// consumer must accept in that same cycle (there is no ready/backpressure),
// and oPix_Address/oPix_Data are meaningful only while oPix_Valid is high.
interface vga_sync_decoder_if;
    logic        iPixEn;
    logic        iVGA_HSync;
    logic        iVGA_VSync;
    logic [9:0]  iVGA_R;
    logic [9:0]  iVGA_G;
    logic [9:0]  iVGA_B;
    logic        oPix_Valid;
    logic [31:0] oPix_Address;
    logic [29:0] oPix_Data;
    logic        oFrame_Start;
    logic        oLocked;
    logic        oErr_Line;
    logic        oErr_Frame;
    logic [1:0]  dbg_state;

    // Video source side: drives syncs/colour, observes the decoded stream.
    modport master (
        output iPixEn, iVGA_HSync, iVGA_VSync, iVGA_R, iVGA_G, iVGA_B,
        input  oPix_Valid, oPix_Address, oPix_Data, oFrame_Start, oLocked,
        input  oErr_Line, oErr_Frame, dbg_state
    );

    // Decoder side.
    modport slave (
        input  iPixEn, iVGA_HSync, iVGA_VSync, iVGA_R, iVGA_G, iVGA_B,
        output oPix_Valid, oPix_Address, oPix_Data, oFrame_Start, oLocked,
        output oErr_Line, oErr_Frame, dbg_state
    );
endinterface

// File: rtl/vga_sync_decoder.sv
// VGA receive-side decoder: recovers x/y from active-low sync edges, checks
// line/frame lengths, runs a lock state machine and emits a registered
// pixel-write stream {y,x} / {B,G,R} once locked.
module vga_sync_decoder #(
    parameter int H_ACTIVE    = 640,
    parameter int H_BP        = 48,
    parameter int H_TOTAL     = 800,
    parameter int V_ACTIVE    = 480,
    parameter int V_BP        = 33,
    parameter int V_TOTAL     = 525,
    parameter int LOCK_FRAMES = 2
) (
    input  logic              iClk_50,
    input  logic              nRst,
    vga_sync_decoder_if.slave bus
);
    typedef enum logic [1:0] {
        UNLOCK = 2'd0,
        ACQ    = 2'd1,
        LOCK   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  gcnt_q, gcnt_d;
    logic        err_seen_q, err_seen_d;   // error seen since last frame start
    logic        hs_q, hs_d, vs_q, vs_d;
    logic [15:0] h_q, h_d, v_q, v_d;
    logic        v_pend_q, v_pend_d;
    logic        h_seen_q, h_seen_d;       // a line start has been seen
    logic        v_seen_q, v_seen_d;       // a frame start has been seen
    logic        pix_valid_q, pix_valid_d;
    logic [31:0] pix_addr_q, pix_addr_d;
    logic [29:0] pix_data_q, pix_data_d;
    logic        frame_start_q, frame_start_d;
    logic        locked_q, locked_d;
    logic        err_line_q, err_line_d;
    logic        err_frame_q, err_frame_d;

    logic hs_rise, vs_rise, fs_ev, line_err, frame_err, any_err, act_x, act_y;

    // Next-state: edge detect, h/v counters, length checks, lock FSM, outputs.
    always_comb begin
        state_d       = state_q;
        gcnt_d        = gcnt_q;
        err_seen_d    = err_seen_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        h_d           = h_q;
        v_d           = v_q;
        v_pend_d      = v_pend_q;
        h_seen_d      = h_seen_q;
        v_seen_d      = v_seen_q;
        pix_valid_d   = 1'b0;
        pix_addr_d    = pix_addr_q;
        pix_data_d    = pix_data_q;
        frame_start_d = 1'b0;
        err_line_d    = 1'b0;
        err_frame_d   = 1'b0;
        hs_rise       = 1'b0;
        vs_rise       = 1'b0;
        fs_ev         = 1'b0;
        line_err      = 1'b0;
        frame_err     = 1'b0;
        any_err       = 1'b0;
        act_x         = 1'b0;
        act_y         = 1'b0;

        if (bus.iPixEn) begin
            hs_d    = bus.iVGA_HSync;
            vs_d    = bus.iVGA_VSync;
            hs_rise = !hs_q && bus.iVGA_HSync;
            vs_rise = !vs_q && bus.iVGA_VSync;
            // A pending VSync rise (or one on this very sample) makes this line 0.
            fs_ev   = hs_rise && (v_pend_q || vs_rise);

            // Compare in 17 bits so a saturated counter cannot alias.
            line_err  = hs_rise && h_seen_q &&
                        (({1'b0, h_q} + 17'd1) != 17'(H_TOTAL));
            frame_err = fs_ev && v_seen_q &&
                        (({1'b0, v_q} + 17'd1) != 17'(V_TOTAL));
            any_err   = line_err || frame_err;

            if (hs_rise) begin
                h_d      = 16'd0;
                h_seen_d = 1'b1;
            end else if (h_q != 16'hFFFF) begin
                h_d = h_q + 16'd1;
            end

            if (fs_ev) begin
                v_d      = 16'd0;
                v_pend_d = 1'b0;
                v_seen_d = 1'b1;
            end else if (hs_rise) begin
                if (v_q != 16'hFFFF) v_d = v_q + 16'd1;
            end else if (vs_rise) begin
                v_pend_d = 1'b1;
            end

            case (state_q)
                UNLOCK: begin
                    if (fs_ev) begin
                        state_d    = ACQ;
                        gcnt_d     = 8'd0;
                        err_seen_d = 1'b0;
                    end
                end
                ACQ: begin
                    if (fs_ev) begin
                        err_seen_d = 1'b0;
                        if (any_err || err_seen_q) begin
                            gcnt_d = 8'd0;
                        end else begin
                            gcnt_d = gcnt_q + 8'd1;
                            if ((gcnt_q + 8'd1) >= 8'(LOCK_FRAMES)) state_d = LOCK;
                        end
                    end else if (any_err) begin
                        gcnt_d     = 8'd0;
                        err_seen_d = 1'b1;
                    end
                end
                LOCK: begin
                    if (any_err) begin
                        state_d    = ACQ;
                        gcnt_d     = 8'd0;
                        // A mid-frame error spoils the frame in progress.
                        err_seen_d = !fs_ev;
                    end
                end
                default: state_d = UNLOCK;
            endcase

            err_line_d    = line_err && (state_q != UNLOCK);
            err_frame_d   = frame_err && (state_q != UNLOCK);
            frame_start_d = fs_ev && (state_d == LOCK);

            act_x = (h_d >= 16'(H_BP)) && (h_d < 16'(H_BP + H_ACTIVE));
            act_y = (v_d >= 16'(V_BP)) && (v_d < 16'(V_BP + V_ACTIVE));
            if (act_x && act_y && (state_d == LOCK)) begin
                pix_valid_d = 1'b1;
                pix_addr_d  = {v_d - 16'(V_BP), h_d - 16'(H_BP)};
                pix_data_d  = {bus.iVGA_B, bus.iVGA_G, bus.iVGA_R};
            end
        end
        locked_d = (state_d == LOCK);
    end

    // State and output registers.
    always_ff @(posedge iClk_50 or negedge nRst) begin
        if (!nRst) begin
            state_q       <= UNLOCK;
            gcnt_q        <= 8'd0;
            err_seen_q    <= 1'b0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            h_q           <= 16'd0;
            v_q           <= 16'd0;
            v_pend_q      <= 1'b0;
            h_seen_q      <= 1'b0;
            v_seen_q      <= 1'b0;
            pix_valid_q   <= 1'b0;
            pix_addr_q    <= 32'd0;
            pix_data_q    <= 30'd0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
            err_line_q    <= 1'b0;
            err_frame_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            gcnt_q        <= gcnt_d;
            err_seen_q    <= err_seen_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            h_q           <= h_d;
            v_q           <= v_d;
            v_pend_q      <= v_pend_d;
            h_seen_q      <= h_seen_d;
            v_seen_q      <= v_seen_d;
            pix_valid_q   <= pix_valid_d;
            pix_addr_q    <= pix_addr_d;
            pix_data_q    <= pix_data_d;
            frame_start_q <= frame_start_d;
            locked_q      <= locked_d;
            err_line_q    <= err_line_d;
            err_frame_q   <= err_frame_d;
        end
    end

    assign bus.oPix_Valid   = pix_valid_q;
    assign bus.oPix_Address = pix_addr_q;
    assign bus.oPix_Data    = pix_data_q;
    assign bus.oFrame_Start = frame_start_q;
    assign bus.oLocked      = locked_q;
    assign bus.oErr_Line    = err_line_q;
    assign bus.oErr_Frame   = err_frame_q;
    assign bus.dbg_state    = state_q;
endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a scaled-down raster (16x9 with an 8x4
// active window) so whole frames stay short; the sync/porch structure and
// lock rules are the same as at 640x480.
module tb_vga_sync_decoder;
    localparam int H_ACTIVE = 8, H_BP = 3, H_TOTAL = 16;
    localparam int V_ACTIVE = 4, V_BP = 2, V_TOTAL = 9;
    localparam int LOCK_FRAMES = 2;

    // Clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    vga_sync_decoder_if bus();

    vga_sync_decoder #(
        .H_ACTIVE(H_ACTIVE), .H_BP(H_BP), .H_TOTAL(H_TOTAL),
        .V_ACTIVE(V_ACTIVE), .V_BP(V_BP), .V_TOTAL(V_TOTAL),
        .LOCK_FRAMES(LOCK_FRAMES)
    ) dut (
        .iClk_50(clk),
        .nRst(rst_n),
        .bus(bus)
    );

    // Scoreboard state
    logic [61:0] exp_q[$];
    logic [61:0] exp_item;
    int errors = 0;
    int checks = 0;
    int n_pix = 0, n_errl = 0, n_errf = 0, n_fs = 0;
    logic [31:0] pix_first = 32'd0, pix_last = 32'd0;
    int lock_rise_frame = -1;
    int cur_frame = -1, cur_line = -1, cur_h = -1;
    int frame_no = 0;
    logic prev_locked = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"},  64'(bus.oPix_Valid),   64'd0);
        check({tag, "_addr"},   64'(bus.oPix_Address), 64'd0);
        check({tag, "_data"},   64'(bus.oPix_Data),    64'd0);
        check({tag, "_fs"},     64'(bus.oFrame_Start), 64'd0);
        check({tag, "_locked"}, 64'(bus.oLocked),      64'd0);
        check({tag, "_errl"},   64'(bus.oErr_Line),    64'd0);
        check({tag, "_errf"},   64'(bus.oErr_Frame),   64'd0);
    endtask

    // Driver: one sample with iPixEn high, then one idle clock.
    task automatic drive_sample(input logic hs, input logic vs,
                                input logic [9:0] r, input logic [9:0] g, input logic [9:0] b,
                                input int f, input int l, input int h);
        @(posedge clk); #1;
        bus.iPixEn     = 1'b1;
        bus.iVGA_HSync = hs;
        bus.iVGA_VSync = vs;
        bus.iVGA_R     = r;
        bus.iVGA_G     = g;
        bus.iVGA_B     = b;
        cur_frame = f; cur_line = l; cur_h = h;
        @(posedge clk); #1;
        bus.iPixEn = 1'b0;
    endtask

    // One frame of nl lines; each line starts on its HSync rise and ends with
    // 2 low-HSync samples. VSync rises mid-way through the last line, or, with
    // simul set, stays low to the end so it rises with the next line 0 HSync.
    // Expected pixels are pushed for active samples on lines < pix_lines.
    task automatic drive_frame(input int nl, input int short_l, input bit simul,
                               input int pix_lines, input int last_line);
        int len, x, y;
        logic hs, vs;
        logic [9:0] r, g, b;
        for (int l = 0; l < last_line; l++) begin
            len = (l == short_l) ? H_TOTAL - 1 : H_TOTAL;
            for (int h = 0; h < len; h++) begin
                hs = (h < len - 2);
                if (simul) vs = !(l >= nl - 2);
                else       vs = !((l == nl - 3) || (l == nl - 2) || (l == nl - 1 && h < 5));
                x = h - H_BP;
                y = l - V_BP;
                r = 10'(x);
                g = 10'(y);
                b = 10'($urandom_range(0, 1023));
                if (l < pix_lines && x >= 0 && x < H_ACTIVE && y >= 0 && y < V_ACTIVE)
                    exp_q.push_back({16'(y), 16'(x), b, g, r});
                drive_sample(hs, vs, r, g, b, frame_no, l, h);
            end
        end
        frame_no++;
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    // Monitor: compare emitted pixels against the queue, count pulses.
    always @(negedge clk) begin
        if (bus.oPix_Valid) begin
            if (exp_q.size() == 0) begin
                check("pix_unexpected", 64'(exp_q.size()), 64'd1);
            end else begin
                exp_item = exp_q.pop_front();
                check("pix", {2'b00, bus.oPix_Address, bus.oPix_Data}, {2'b00, exp_item});
            end
            if (n_pix == 0) pix_first = bus.oPix_Address;
            pix_last = bus.oPix_Address;
            n_pix++;
        end
        if (bus.oErr_Line)    n_errl++;
        if (bus.oErr_Frame)   n_errf++;
        if (bus.oFrame_Start) n_fs++;
        if (bus.oLocked && !prev_locked) begin
            lock_rise_frame = cur_frame;
            check("lock_with_fs", 64'(bus.oFrame_Start), 64'd1);
        end
        if (!bus.oLocked && prev_locked && rst_n)
            check("lockfall_with_err", 64'(bus.oErr_Line | bus.oErr_Frame), 64'd1);
        prev_locked = bus.oLocked;
    end

    // Watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    // Directed sequence
    initial begin
        bus.iPixEn = 1'b0; bus.iVGA_HSync = 1'b1; bus.iVGA_VSync = 1'b1;
        bus.iVGA_R = '0; bus.iVGA_G = '0; bus.iVGA_B = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;

        // Acquire: frame starts at frames 1,2,3; lock at the third.
        for (int f = 0; f < 3; f++) drive_frame(V_TOTAL, -1, 1'b0, 0, V_TOTAL);
        settle();
        check("acq_not_locked", 64'(bus.oLocked), 64'd0);
        check("acq_no_pix", 64'(n_pix), 64'd0);
        n_pix = 0;
        drive_frame(V_TOTAL, -1, 1'b0, V_TOTAL, V_TOTAL);   // frame 3
        settle();
        check("lock_locked", 64'(bus.oLocked), 64'd1);
        check("lock_rise_frame", 64'(lock_rise_frame), 64'd3);
        check("lock_pix_count", 64'(n_pix), 64'(H_ACTIVE * V_ACTIVE));
        check("lock_first_addr", 64'(pix_first), 64'h0);
        check("lock_last_addr", 64'(pix_last), 64'h0003_0007);
        check("lock_errl", 64'(n_errl), 64'd0);
        check("lock_errf", 64'(n_errf), 64'd0);
        check("lock_fs_count", 64'(n_fs), 64'd1);

        // Simultaneous VSync/HSync rise at the start of frame 5.
        drive_frame(V_TOTAL, -1, 1'b1, V_TOTAL, V_TOTAL);   // frame 4
        n_pix = 0;
        drive_frame(V_TOTAL, -1, 1'b0, V_TOTAL, V_TOTAL);   // frame 5
        settle();
        check("simul_pix_count", 64'(n_pix), 64'(H_ACTIVE * V_ACTIVE));
        check("simul_first_addr", 64'(pix_first), 64'h0);
        check("simul_no_err", 64'(n_errl + n_errf), 64'd0);
        check("simul_fs_count", 64'(n_fs), 64'd3);
        check("simul_locked", 64'(bus.oLocked), 64'd1);

        // Short line (line 3 of frame 6): error at line 4 start, lock lost.
        n_pix = 0;
        drive_frame(V_TOTAL, 3, 1'b0, 4, V_TOTAL);          // frame 6
        settle();
        check("short_errl", 64'(n_errl), 64'd1);
        check("short_unlocked", 64'(bus.oLocked), 64'd0);
        check("short_pix_count", 64'(n_pix), 64'(2 * H_ACTIVE));
        n_pix = 0;
        drive_frame(V_TOTAL, -1, 1'b0, 0, V_TOTAL);          // frame 7
        drive_frame(V_TOTAL, -1, 1'b0, 0, V_TOTAL);          // frame 8
        settle();
        check("short_still_unlocked", 64'(bus.oLocked), 64'd0);
        check("short_no_pix", 64'(n_pix), 64'd0);
        n_pix = 0;
        drive_frame(V_TOTAL, -1, 1'b0, V_TOTAL, V_TOTAL);   // frame 9
        settle();
        check("relock_locked", 64'(bus.oLocked), 64'd1);
        check("relock_frame", 64'(lock_rise_frame), 64'd9);
        check("relock_pix_count", 64'(n_pix), 64'(H_ACTIVE * V_ACTIVE));
        check("relock_errl", 64'(n_errl), 64'd1);

        // Long frame (10 lines): frame error at frame 11 start.
        n_pix = 0;
        drive_frame(V_TOTAL + 1, -1, 1'b0, V_TOTAL + 1, V_TOTAL + 1);  // frame 10
        drive_frame(V_TOTAL, -1, 1'b0, 0, V_TOTAL);                    // frame 11
        settle();
        check("long_errf", 64'(n_errf), 64'd1);
        check("long_unlocked", 64'(bus.oLocked), 64'd0);
        check("long_pix_count", 64'(n_pix), 64'(H_ACTIVE * V_ACTIVE));
        check("long_errl", 64'(n_errl), 64'd1);
        drive_frame(V_TOTAL, -1, 1'b0, 0, V_TOTAL);                    // frame 12
        drive_frame(V_TOTAL, -1, 1'b0, 3, 3);                          // frame 13, partial
        settle();
        check("long_relock_frame", 64'(lock_rise_frame), 64'd13);
        check("long_relock_locked", 64'(bus.oLocked), 64'd1);

        // Reset mid-frame while locked.
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_zero("rst_mid");
        for (int i = 0; i < 10; i++)
            drive_sample(1'b1, 1'b1, 10'(i), 10'(i + 1), 10'(i + 2), -1, -1, i);
        settle();
        check_zero("rst_hold");
        check("rst_queue_empty", 64'(exp_q.size()), 64'd0);
        rst_n = 1'b1;
        n_pix = 0;
        for (int f = 0; f < 3; f++) drive_frame(V_TOTAL, -1, 1'b0, 0, V_TOTAL);  // 14..16
        settle();
        check("rst_not_locked", 64'(bus.oLocked), 64'd0);
        check("rst_no_pix", 64'(n_pix), 64'd0);
        drive_frame(V_TOTAL, -1, 1'b0, V_TOTAL, V_TOTAL);                        // 17
        settle();
        check("rst_relock_frame", 64'(lock_rise_frame), 64'd17);
        check("rst_relock_locked", 64'(bus.oLocked), 64'd1);
        check("rst_pix_count", 64'(n_pix), 64'(H_ACTIVE * V_ACTIVE));

        repeat (4) @(negedge clk);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Receive-side counterpart of the 640x480 VGA timing generator. Samples an active-low HSync/VSync pair and 30-bit RGB on a pixel-rate enable, recovers x/y coordinates from the sync edges, checks line and frame length, and emits a locked pixel-write stream `{y,x}` / color for a capture frame buffer or a self-checking bench. All logic runs on one clock; sync and color inputs are synchronous to it.

## Interface
- `H_ACTIVE`, 640: active pixels per line.
- `H_BP`, 48: back-porch pixels between HSync rise and first active pixel.
- `H_TOTAL`, 800: pixels per line, sync to sync.
- `V_ACTIVE`, 480: active lines per frame.
- `V_BP`, 33: back-porch lines between frame start and first active line.
- `V_TOTAL`, 525: lines per frame.
- `LOCK_FRAMES`, 2: consecutive error-free frames required to lock.
- `iClk_50` in 1: system clock; the only clock.
- `nRst` in 1: asynchronous, active-low reset.
- `iPixEn` in 1: pixel sample strobe; inputs are sampled only when high.
- `iVGA_HSync`, `iVGA_VSync` in 1: active-low syncs.
- `iVGA_R`, `iVGA_G`, `iVGA_B` in 10 each: color.
- `oPix_Valid` out 1: one-cycle pulse per captured active pixel.
- `oPix_Address` out 32: `{y[15:0], x[15:0]}`.
- `oPix_Data` out 30: `{B,G,R}`, with R in `[9:0]`.
- `oFrame_Start` out 1: one-cycle pulse at line 0 of each frame while locked.
- `oLocked` out 1: lock status.
- `oErr_Line`, `oErr_Frame` out 1: one-cycle pulses on a length mismatch.

## Operation
- **Edge detect.**
  - Previous-sample registers `hs_q` and `vs_q` reset to 1.
  - A rise is `prev==0 && cur==1` on an `iPixEn` cycle.
  - Nothing updates on cycles with `iPixEn=0`.
- **Horizontal.**
  - The sample that detects an HSync rise has h index 0.
  - Each later sample increments the index, saturating at 16'hFFFF.
  - The sample is active-x when `H_BP <= h < H_BP+H_ACTIVE`, with `x = h - H_BP`.
- **Line check.**
  - At each HSync rise after the first since reset/unlock, compare `(last h)+1` with `H_TOTAL`.
  - On mismatch, pulse `oErr_Line`.
- **Vertical.**
  - A VSync rise sets `v_pend`.
  - The next HSync rise, including one on the same sample, sets the line index v to 0 and clears `v_pend`.
  - Every other HSync rise increments v, saturating.
  - The line is active-y when `V_BP <= v < V_BP+V_ACTIVE`, with `y = v - V_BP`.
- **Frame check.** At the v-to-0 rise, if a previous frame start exists, compare `(last v)+1` with `V_TOTAL`; on mismatch, pulse `oErr_Frame`.
- **Lock FSM**, with good-frame counter `gcnt`:
  - `UNLOCK`: on the first frame start, go to `ACQ` with `gcnt=0`.
  - `ACQ`: each frame start with no error since the previous one increments `gcnt`.
    - When `gcnt` reaches `LOCK_FRAMES`, go to `LOCK`.
    - Any error sets `gcnt=0` and stays in `ACQ`.
  - `LOCK`: any line or frame error goes to `ACQ` with `gcnt=0`.
- **Output gating.**
  - `oPix_Valid` is high only in `LOCK` for samples that are both active-x and active-y.
  - `oFrame_Start` fires only when the FSM is in `LOCK` at the v-to-0 rise.
  - `oLocked` is high exactly in `LOCK`.
  - Errors pulse in every state except `UNLOCK`.
- **Address width.**
  - x and y are zero-extended to 16 bits.
  - Upper address bits are always 0 for the default parameters.

## Timing
- **Reset values.**
  - FSM is in `UNLOCK`.
  - All outputs are 0.
  - h, v, and `gcnt` are 0.
  - `v_pend` is 0.
  - `hs_q`/`vs_q` are 1.
- **Latency.** All outputs are registered: a sample at clock edge N produces its outputs valid after edge N+1, i.e. one `iClk_50` cycle.
- **Pixel data.** `oPix_Data`/`oPix_Address` hold their value until the next valid pixel; they are meaningful only while `oPix_Valid` is high.
- **Lock timing.** `oLocked` rises in the same cycle as the `oFrame_Start` pulse that completes the lock.
- **Lock loss.** An error pulse and `oLocked` falling occur in the same cycle; the pixel on that sample is not emitted.
- **Sample gaps.** Any `iPixEn` gap pattern is legal; counts advance per sample, not per clock.
- **Reset mid-frame.** Outputs clear immediately. Lock requires the first frame start after release plus `LOCK_FRAMES` good frames.

## Test plan
- **Acquire lock.** Drive 4 nominal 800x525 frames (HSync low for 96 pixels, VSync low for 2 lines, `iPixEn` every 2nd clock) from the VGA controller model. Required: `oLocked` rises at the 3rd frame start, and no errors.
- **Pixel mapping.** After lock, drive color = `{y,x}` pattern. Required:
  - 307200 `oPix_Valid` pulses per frame.
  - First pulse has address 32'h0000_0000; last has 32'h01DF_027F.
  - Data matches input one cycle later.
- **Short line.** One 799-pixel line while locked. Required:
  - `oErr_Line` pulses once.
  - `oLocked` falls and no pixels are emitted until relock, 2 good frames later.
- **Long frame.** One 526-line frame. Required: `oErr_Frame` at the next frame start, and `oLocked` falls.
- **Reset mid-frame.** Assert `nRst` at line 200. Required:
  - All outputs are 0 while reset is held.
  - After release, `oLocked` stays 0 until the 3rd frame start.
- **Simultaneous edges.** VSync and HSync rise on the same sample. Required:
  - v=0 on that line.
  - First pixel address is 32'h0000_0000 at line 33, h=48.
